// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch controller.
// Turns a taken-branch decision into a one-shot PC redirect and a timed
// squash of the younger stages. It also holds the Z/N/C flag register that
// feeds branch evaluation, and clears the tested flag when a conditional
// jump is taken.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall           pipeline freeze; all state holds while high
//   jump            taken decision for the EX instruction
//   branch[2:0]     100 JMP, 101 JZ, 110 JN, 111 JC, anything else = none
//   jump_target     redirect address of the EX instruction
//   flag_we         ALU flag write enable
//   alu_z/n/c       flag values from the ALU
//   pc_load         PC loads pc_target (held until the first unstalled flush cycle)
//   pc_target       registered redirect address
//   flush           clear IF/ID and ID/EX valid bits
//   busy            controller is in its flush window
//   z, n, c         flag register contents
module branch_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [2:0]            branch,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  flag_we,
  input  logic                  alu_z,
  input  logic                  alu_n,
  input  logic                  alu_c,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  flush,
  output logic                  busy,
  output logic                  z,
  output logic                  n,
  output logic                  c
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  pc_load_n, flush_n, busy_n;
  logic [ADDR_WIDTH-1:0] pc_target_n;
  logic                  z_n, n_n, c_n;
  logic                  accept;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pc_load_n   = pc_load;
    pc_target_n = pc_target;
    flush_n     = flush;
    busy_n      = busy;
    z_n         = z;
    n_n         = n;
    c_n         = c;
    accept      = 1'b0;

    if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (jump) begin
            accept      = 1'b1;
            state_n     = ST_FLUSH;
            cnt_n       = FLUSH_INIT;
            pc_load_n   = 1'b1;
            flush_n     = 1'b1;
            busy_n      = 1'b1;
            pc_target_n = jump_target;
          end
        end
        ST_FLUSH: begin
          // jump/jump_target here belong to squashed instructions: ignored.
          cnt_n     = cnt - 4'd1;
          pc_load_n = 1'b0;
          // Last flush cycle: counter is about to hit zero.
          if (cnt <= 4'd1) begin
            cnt_n   = 4'd0;
            state_n = ST_IDLE;
            flush_n = 1'b0;
            busy_n  = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase

      // A fresh ALU write wins over clear-on-use of the tested flag.
      if (flag_we) begin
        z_n = alu_z;
        n_n = alu_n;
        c_n = alu_c;
      end else if (accept) begin
        case (branch)
          3'b101:  z_n = 1'b0;
          3'b110:  n_n = 1'b0;
          3'b111:  c_n = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      flush     <= 1'b0;
      busy      <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pc_load   <= pc_load_n;
      pc_target <= pc_target_n;
      flush     <= flush_n;
      busy      <= busy_n;
      z         <= z_n;
      n         <= n_n;
      c         <= c_n;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the controller rules.
module tb_branch_ctrl;
  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1, stall = 1'b0, jump = 1'b0;
  logic [2:0]    branch = 3'b000;
  logic [AW-1:0] jump_target = '0;
  logic          flag_we = 1'b0, alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0;
  logic          pc_load, flush, busy, z, n, c;
  logic [AW-1:0] pc_target;

  int checks = 0;
  int errors = 0;

  // Reference model: flush cycles still owed, pending PC load, flags.
  int          m_left = 0;
  logic        m_load = 1'b0;
  logic [AW-1:0] m_tgt = '0;
  logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0;

  branch_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .branch(branch),
    .jump_target(jump_target), .flag_we(flag_we),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
    .pc_load(pc_load), .pc_target(pc_target), .flush(flush), .busy(busy),
    .z(z), .n(n), .c(c)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_left = 0; m_load = 0; m_tgt = '0; m_z = 0; m_n = 0; m_c = 0;
    end else if (!stall) begin
      acc = (m_left == 0) && jump;
      if (flag_we) begin
        m_z = alu_z; m_n = alu_n; m_c = alu_c;
      end else if (acc) begin
        if (branch == 3'd5) m_z = 0;
        if (branch == 3'd6) m_n = 0;
        if (branch == 3'd7) m_c = 0;
      end
      if (acc) begin
        m_left = FC; m_load = 1; m_tgt = jump_target;
      end else if (m_left > 0) begin
        m_left--; m_load = 0;
      end
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; jump = 0; branch = 0; flag_we = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (FC + 1) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      stall = 1'($urandom); jump = 1'($urandom); branch = 3'($urandom);
      jump_target = $urandom; flag_we = 1'($urandom);
      alu_z = 1'($urandom); alu_n = 1'($urandom); alu_c = 1'($urandom);
      tick();
    end
    checks++;
    if ({pc_load, flush, busy, z, n, c} !== 6'b0 || pc_target !== '0) begin
      errors++;
      $display("FAIL reset: got ld/fl/bsy/znc=%b tgt=%h, want 000000 tgt=0",
               {pc_load, flush, busy, z, n, c}, pc_target);
    end
    idle_inputs();
  endtask

  task automatic test_uncond();
    flag_we = 1; alu_z = 1; alu_n = 0; alu_c = 1;
    tick();
    flag_we = 0; jump = 1; branch = 3'b100; jump_target = 32'h40;
    tick();
    checks++;
    if ({pc_load, flush, busy} !== 3'b111 || pc_target !== 32'h40 ||
        {z, n, c} !== 3'b101) begin
      errors++;
      $display("FAIL jmp_t1: got ld/fl/bsy=%b tgt=%h znc=%b, want 111 tgt=40 znc=101",
               {pc_load, flush, busy}, pc_target, {z, n, c});
    end
    jump = 0;
    tick();
    checks++;
    if ({pc_load, flush, busy} !== 3'b011) begin
      errors++;
      $display("FAIL jmp_t2: got ld/fl/bsy=%b want 011", {pc_load, flush, busy});
    end
    tick();
    checks++;
    if ({pc_load, flush, busy} !== 3'b000 || pc_target !== 32'h40) begin
      errors++;
      $display("FAIL jmp_t3: got ld/fl/bsy=%b tgt=%h want 000 tgt=40",
               {pc_load, flush, busy}, pc_target);
    end
    drain();
  endtask

  task automatic test_cond_clear();
    logic [2:0] want;
    for (int k = 5; k <= 7; k++) begin
      flag_we = 1; alu_z = 1; alu_n = 1; alu_c = 1;
      tick();
      flag_we = 0; jump = 1; branch = 3'(k); jump_target = 32'(k * 16);
      tick();
      want = (k == 5) ? 3'b011 : (k == 6) ? 3'b101 : 3'b110;
      checks++;
      if ({z, n, c} !== want || pc_load !== 1'b1) begin
        errors++;
        $display("FAIL cond_clear code=%0d: got znc=%b ld=%b want znc=%b ld=1",
                 k, {z, n, c}, pc_load, want);
      end
      drain();
    end
  endtask

  task automatic test_stall_mid_flush();
    jump = 1; branch = 3'b100; jump_target = 32'h80;
    tick();
    jump = 0;
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (pc_load !== (i <= 4) || flush !== (i <= 5) || busy !== (i <= 5) ||
          pc_target !== 32'h80) begin
        errors++;
        $display("FAIL stall_flush cyc=%0d: got ld/fl/bsy=%b tgt=%h want %b%b%b tgt=80",
                 i, {pc_load, flush, busy}, pc_target, i <= 4, i <= 5, i <= 5);
      end
      stall = (i <= 3);
      jump = 1; jump_target = 32'hDEAD;  // must be ignored while flushing
      if (i == 5) jump = 0;
      tick();
      jump = 0;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    jump = 1; branch = 3'b100; jump_target = 32'h10;
    tick();
    jump_target = 32'h20;
    for (int i = 0; i < FC; i++) begin
      checks++;
      if (pc_target !== 32'h10 || flush !== 1'b1) begin
        errors++;
        $display("FAIL b2b_hold i=%0d: got tgt=%h fl=%b want tgt=10 fl=1",
                 i, pc_target, flush);
      end
      tick();
    end
    checks++;
    if (flush !== 1'b0 || pc_load !== 1'b0 || pc_target !== 32'h10) begin
      errors++;
      $display("FAIL b2b_idle: got fl=%b ld=%b tgt=%h want 0 0 10", flush, pc_load, pc_target);
    end
    jump_target = 32'h30;
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 32'h30) begin
      errors++;
      $display("FAIL b2b_second: got ld=%b tgt=%h want ld=1 tgt=30", pc_load, pc_target);
    end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    jump = 1; branch = 3'b100; jump_target = 32'h44;
    tick();
    jump = 0; rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({pc_load, flush, busy} !== 3'b000 || pc_target !== '0) begin
      errors++;
      $display("FAIL rst_mid_flush: got ld/fl/bsy=%b tgt=%h want 000 tgt=0",
               {pc_load, flush, busy}, pc_target);
    end
    drain();
  endtask

  task automatic test_flag_priority();
    flag_we = 1; alu_z = 1; alu_n = 0; alu_c = 0;
    jump = 1; branch = 3'b101; jump_target = 32'h50;
    tick();
    checks++;
    if (z !== 1'b1 || pc_load !== 1'b1) begin
      errors++;
      $display("FAIL flag_priority: got z=%b ld=%b want z=1 ld=1", z, pc_load);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      jump = 1'($urandom);
      branch = 3'($urandom);
      jump_target = $urandom;
      flag_we = ($urandom_range(0, 3) == 0);
      alu_z = 1'($urandom); alu_n = 1'($urandom); alu_c = 1'($urandom);
      tick();
      checks++;
      if ({pc_load, flush, busy, z, n, c} !==
          {m_load, m_left > 0, m_left > 0, m_z, m_n, m_c} || pc_target !== m_tgt) begin
        errors++;
        $display("FAIL random cyc=%0d: got ld/fl/bsy/znc=%b tgt=%h want %b tgt=%h",
                 i, {pc_load, flush, busy, z, n, c}, pc_target,
                 {m_load, m_left > 0, m_left > 0, m_z, m_n, m_c}, m_tgt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_uncond();
    test_cond_clear();
    test_stall_mid_flush();
    test_back_to_back();
    test_reset_mid_flush();
    test_flag_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Pipeline branch controller for the EX stage. It takes the taken/not-taken decision from the branch evaluation logic and the instruction's branch code, then drives a PC redirect and a timed flush of the younger pipeline stages. It also owns the architectural Z/N/C flag register that feeds the branch evaluation logic, including clear-on-use for taken conditional jumps. It sits between the EX stage, the PC register and the IF/ID and ID/EX valid bits.

## Interface
- ADDR_WIDTH, 32, width of PC/jump target
- FLUSH_CYCLES, 2, number of cycles younger stages are squashed after a taken jump (legal range 1..15)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline freeze (memory wait); holds all state when high
- jump  in  1  taken decision from branch evaluation (already gated by EX valid)
- branch  in  3  branch code of EX instruction: 100 JMP, 101 JZ, 110 JN, 111 JC, other = none
- jump_target  in  ADDR_WIDTH  destination address of EX instruction
- flag_we  in  1  ALU flag write enable
- alu_z, alu_n, alu_c  in  1 each  flag values from ALU
- pc_load  out  1  PC register loads pc_target this cycle
- pc_target  out  ADDR_WIDTH  registered redirect address
- flush  out  1  clear valid of IF/ID and ID/EX
- busy  out  1  controller in FLUSH state
- z, n, c  out  1 each  registered flag register contents

## Operation
- All outputs registered; reset values: pc_load 0, pc_target 0, flush 0, busy 0, z/n/c 0, state IDLE, counter 0.
- States: IDLE, FLUSH. Down-counter cnt, 4 bits.
- IDLE: on an edge with jump=1 and stall=0:
  - capture jump_target into pc_target
  - go to FLUSH with cnt=FLUSH_CYCLES
  - set pc_load=1, flush=1, busy=1
- IDLE with stall=1: jump is not sampled; no state change.
- FLUSH: jump and jump_target are ignored (they belong to squashed instructions).
  - Each edge with stall=0 decrements cnt and clears pc_load.
  - When cnt reaches 0, return to IDLE and clear flush/busy.
  - With stall=1, cnt, pc_load, flush and pc_target hold their values.
- pc_load therefore stays high until the first non-stalled FLUSH cycle, and the PC consumes it exactly once.
- Flag register, updated only on edges with stall=0, per bit:
  - flag_we=1: load alu_z/alu_n/alu_c. This has priority over clear.
  - Otherwise, a taken jump accepted in IDLE clears the flag it tested: JZ clears z, JN clears n, JC clears c. JMP clears nothing.
  - Otherwise, hold.
- Any branch code outside 100..111 never clears a flag, even if jump=1.
- rst=1 at any time, including mid-FLUSH or during stall, forces all reset values on that edge.

## Timing
- Jump sampled at edge T → pc_load/flush/busy high after T, i.e. in cycle T+1. Latency is 1 cycle.
- With no stalls, flush is high for exactly FLUSH_CYCLES cycles (T+1..T+FLUSH_CYCLES) and pc_load for exactly 1 cycle (T+1).
- The earliest next accepted jump is sampled at the edge ending cycle T+FLUSH_CYCLES+1, i.e. the first IDLE cycle.
- k stall cycles during FLUSH extend flush/busy by k cycles. If the stall overlaps cycle T+1, pc_load is also extended by k.
- Flag clear is visible on z/n/c in cycle T+1, the same cycle as pc_load.
- A flag_we in the same cycle as an accepted JZ/JN/JC loads the ALU values; no clear occurs.

## Test plan
- Reset: drive random inputs with rst=1 for 3 cycles → all outputs 0, busy 0.
- Unconditional jump: branch=100, jump=1, jump_target=0x0000_0040, FLUSH_CYCLES=2 → pc_load=1 for 1 cycle with pc_target=0x40; flush=1 for 2 cycles; z/n/c unchanged.
- Conditional clear: flag_we with alu_z=1,n=1,c=1, then JZ taken → next cycle z=0, n=1, c=1, pc_load=1. Repeat for JN (clears n) and JC (clears c).
- Stall mid-flush: jump at T, stall=1 during cycles T+1..T+3 → pc_load high T+1..T+4, flush high T+1..T+5, pc_target stable.
- Back-to-back: jump=1 held continuously with targets 0x10 then 0x20 → second target ignored during FLUSH; the next redirect is sampled in the first IDLE cycle with whatever target is present then.
- Reset mid-flush and flag priority: rst in cycle T+1 → flush/busy/pc_load 0 at T+2. Separately, flag_we=1 with alu_z=1 together with a taken JZ → z=1 next cycle.
